// File: rtl/call_stack_pkg.sv
// Shared constants for the return-address call stack.
package call_stack_pkg;

  // Program counter width; one stored return address is this wide.
  localparam int PC_WIDTH    = 10;
  // Number of nested calls the stack can hold.
  localparam int STACK_DEPTH = 8;

  // Width of an occupancy count that must represent 0..depth inclusive.
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/call_stack_if.sv
// Bus between the datapath and the call stack.
//
// push/pop are single-cycle requests sampled on every rising clock edge;
// there is no ready/back-pressure. The stack always accepts the request and
// reports a refused push (full) through ovf and a refused pop (empty)
// through unf. push together with pop replaces the top entry. q is the
// current top entry and is valid in the same cycle as a pop.
interface call_stack_if
  import call_stack_pkg::*;
#(
  parameter int WIDTH = PC_WIDTH,
  parameter int DEPTH = STACK_DEPTH
);
  localparam int CW = count_width(DEPTH);

  logic             push;
  logic             pop;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic [CW-1:0]    count;
  logic             empty;
  logic             full;
  logic             ovf;
  logic             unf;

  modport master (
    output push, pop, d,
    input  q, count, empty, full, ovf, unf
  );

  modport slave (
    input  push, pop, d,
    output q, count, empty, full, ovf, unf
  );
endinterface

// File: rtl/call_stack_sp_counter.sv
// Stack pointer: saturating up/down occupancy counter with full/empty.
module sp_counter
  import call_stack_pkg::*;
#(
  parameter int DEPTH = STACK_DEPTH,
  parameter int CW    = count_width(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          up_i,
  input  logic          down_i,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  // Next count: up and down together cancel; never passes DEPTH or 0.
  always_comb begin
    count_d = count_q;
    if (up_i && !down_i && !full_o) begin
      count_d = count_q + CW'(1);
    end else if (down_i && !up_i && !empty_o) begin
      count_d = count_q - CW'(1);
    end
  end

  // Occupancy register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/call_stack.sv
// Return-address stack: DEPTH x WIDTH registers addressed by the occupancy
// count, with sticky overflow/underflow flags.
module call_stack
  import call_stack_pkg::*;
#(
  parameter int WIDTH = PC_WIDTH,
  parameter int DEPTH = STACK_DEPTH
) (
  input logic         clk,
  input logic         reset,
  call_stack_if.slave cs
);

  localparam int CW = count_width(DEPTH);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             up, down;
  logic             wr_en;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    top_idx;

  sp_counter #(.DEPTH(DEPTH), .CW(CW)) u_sp (
    .clk     (clk),
    .reset   (reset),
    .up_i    (up),
    .down_i  (down),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  assign top_idx = AW'(count - CW'(1));

  // Decode push/pop into pointer moves, a memory write and flag updates.
  always_comb begin
    up     = 1'b0;
    down   = 1'b0;
    wr_en  = 1'b0;
    wr_idx = AW'(count);
    ovf_d  = ovf_q;
    unf_d  = unf_q;
    if (cs.push && cs.pop) begin
      wr_en = 1'b1;
      if (empty) begin
        // Nothing to return from: perform the call, flag the bad return.
        up    = 1'b1;
        unf_d = 1'b1;
      end else begin
        // Tail call: overwrite the top entry in place.
        wr_idx = top_idx;
      end
    end else if (cs.push) begin
      if (full) begin
        ovf_d = 1'b1;
      end else begin
        up    = 1'b1;
        wr_en = 1'b1;
      end
    end else if (cs.pop) begin
      if (empty) begin
        unf_d = 1'b1;
      end else begin
        down = 1'b1;
      end
    end
  end

  // Entry storage; not cleared by reset, entries above count are unreachable.
  always_ff @(posedge clk) begin
    if (!reset && wr_en) begin
      mem_q[wr_idx] <= cs.d;
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign cs.q     = empty ? '0 : mem_q[top_idx];
  assign cs.count = count;
  assign cs.empty = empty;
  assign cs.full  = full;
  assign cs.ovf   = ovf_q;
  assign cs.unf   = unf_q;

endmodule

// File: tb/tb_call_stack.sv
// Directed self-checking bench for call_stack.
module tb_call_stack;

  localparam int WIDTH = 10;
  localparam int DEPTH = 8;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  call_stack_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) cs ();

  call_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .cs    (cs)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Driver: hold the request for one clock edge, then go idle.
  task automatic step(input logic p, input logic o, input logic [WIDTH-1:0] dd);
    cs.push = p;
    cs.pop  = o;
    cs.d    = dd;
    @(posedge clk);
    #1;
    cs.push = 1'b0;
    cs.pop  = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic check_state(input string tag, input int c, input logic [WIDTH-1:0] qv,
                             input logic ov, input logic un);
    check({tag, ".count"}, 32'(cs.count), 32'(c));
    check({tag, ".q"},     32'(cs.q),     32'(qv));
    check({tag, ".empty"}, 32'(cs.empty), 32'(c == 0));
    check({tag, ".full"},  32'(cs.full),  32'(c == DEPTH));
    check({tag, ".ovf"},   32'(cs.ovf),   32'(ov));
    check({tag, ".unf"},   32'(cs.unf),   32'(un));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset    = 1'b1;
    cs.push  = 1'b0;
    cs.pop   = 1'b0;
    cs.d     = '0;
    @(posedge clk);
    do_reset();
    check_state("reset", 0, 10'h000, 1'b0, 1'b0);

    // Two calls then a return.
    step(1'b1, 1'b0, 10'h005);
    step(1'b1, 1'b0, 10'h123);
    check_state("push2", 2, 10'h123, 1'b0, 1'b0);
    cs.pop = 1'b1;
    #1;
    check("pop_same_cycle_q", 32'(cs.q), 32'h123);
    step(1'b0, 1'b1, 10'h000);
    check_state("pop1", 1, 10'h005, 1'b0, 1'b0);

    // Fill to DEPTH, then overflow.
    do_reset();
    for (int i = 1; i <= DEPTH; i++) begin
      step(1'b1, 1'b0, WIDTH'(i));
      check("fill.q", 32'(cs.q), 32'(i));
      check("fill.count", 32'(cs.count), 32'(i));
    end
    check("fill.full", 32'(cs.full), 32'h1);
    step(1'b1, 1'b0, 10'h3FF);
    check_state("ovf", 8, 10'h008, 1'b1, 1'b0);
    // Replace top while full: allowed, no new flag.
    step(1'b1, 1'b1, 10'h2AA);
    check_state("replace_full", 8, 10'h2AA, 1'b1, 1'b0);
    // Drain: each pop sees the current top.
    for (int i = DEPTH; i >= 1; i--) begin
      check("drain.q", 32'(cs.q), (i == DEPTH) ? 32'h2AA : 32'(i));
      step(1'b0, 1'b1, 10'h000);
    end
    check_state("drained", 0, 10'h000, 1'b1, 1'b0);

    // Underflow on empty pop, then a push.
    do_reset();
    step(1'b0, 1'b1, 10'h000);
    check_state("unf", 0, 10'h000, 1'b0, 1'b1);
    step(1'b1, 1'b0, 10'h010);
    check_state("unf_push", 1, 10'h010, 1'b0, 1'b1);

    // push+pop on empty: push happens, unf set.
    do_reset();
    step(1'b1, 1'b1, 10'h077);
    check_state("pp_empty", 1, 10'h077, 1'b0, 1'b1);

    // push+pop with count=3 replaces top.
    do_reset();
    step(1'b1, 1'b0, 10'h001);
    step(1'b1, 1'b0, 10'h002);
    step(1'b1, 1'b0, 10'h020);
    check_state("pre_replace", 3, 10'h020, 1'b0, 1'b0);
    step(1'b1, 1'b1, 10'h0AA);
    check_state("replace", 3, 10'h0AA, 1'b0, 1'b0);
    step(1'b0, 1'b1, 10'h000);
    check_state("replace_pop", 2, 10'h002, 1'b0, 1'b0);

    // Reset wins over push with count=5 and ovf=1.
    do_reset();
    for (int i = 0; i < DEPTH + 1; i++) begin
      step(1'b1, 1'b0, WIDTH'(10'h040 + i));
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 10'h000);
    end
    check_state("pre_rst", 5, 10'h044, 1'b1, 1'b0);
    reset   = 1'b1;
    cs.push = 1'b1;
    cs.d    = 10'h155;
    @(posedge clk);
    #1;
    reset   = 1'b0;
    cs.push = 1'b0;
    check_state("rst_push", 0, 10'h000, 1'b0, 1'b0);
    step(1'b0, 1'b1, 10'h000);
    check_state("rst_unreach", 0, 10'h000, 1'b0, 1'b1);
    step(1'b1, 1'b0, 10'h009);
    check_state("rst_reuse", 1, 10'h009, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
